// File: rtl/alu_writeback_if.sv
// alu_writeback_if: input bus of the ALU writeback stage.
//   Carries the decoded instruction (opcode, rdst1/rdst2), the divisor operand,
//   every ALU result word and the 2*WIDTH MUL product, plus the
//   in_valid/in_ready handshake.
//   master: instruction source (drives everything except in_ready).
//   slave : writeback stage (drives in_ready only).
interface alu_writeback_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [5:0]           opcode;
  logic [ADDR_W-1:0]    rdst1;
  logic [ADDR_W-1:0]    rdst2;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     negate;
  logic [WIDTH-1:0]     divi;
  logic [WIDTH-1:0]     or_gat;
  logic [WIDTH-1:0]     xor_gat;
  logic [WIDTH-1:0]     nand_gat;
  logic [WIDTH-1:0]     nor_gat;
  logic [WIDTH-1:0]     xnor_gat;
  logic [WIDTH-1:0]     not_gat;
  logic [2*WIDTH-1:0]   multiplied;

  modport master (
    output in_valid, opcode, rdst1, rdst2, op_a,
           sum, diff, negate, divi, or_gat, xor_gat,
           nand_gat, nor_gat, xnor_gat, not_gat, multiplied,
    input  in_ready
  );

  modport slave (
    input  in_valid, opcode, rdst1, rdst2, op_a,
           sum, diff, negate, divi, or_gat, xor_gat,
           nand_gat, nor_gat, xnor_gat, not_gat, multiplied,
    output in_ready
  );
endinterface

// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage after the ALU result mux.
//   Accepts one decoded ALU instruction per handshake, selects the result word
//   by opcode and drives the register-file write port. MUL writes its product
//   over two cycles (low word to rdst1, then high word to rdst2).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : instruction/result inputs and in_valid/in_ready
//   wr_en/addr/data   : registered register-file write port
//   flag_zero/neg     : flags of the last retired result
//   err_illegal/div0  : one-cycle error pulses
//   retired           : retired-instruction counter (wraps)
module alu_writeback #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_writeback_if.slave    bus,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              flag_zero,
  output logic              flag_neg,
  output logic              err_illegal,
  output logic              err_div0,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic {IDLE, BUSY_HI} state_t;

  state_t            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic              flag_zero_q, flag_zero_d;
  logic              flag_neg_q, flag_neg_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_div0_q, err_div0_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [WIDTH-1:0]  hi_data_q, hi_data_d;
  logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;

  logic              accept;
  logic [WIDTH-1:0]  sel;
  logic              is_legal;
  logic              is_mul;
  logic              is_div;

  assign bus.in_ready = (state_q != BUSY_HI);
  assign accept       = bus.in_valid && bus.in_ready;

  // Opcode decode and result select.
  always_comb begin
    sel      = '0;
    is_legal = 1'b1;
    is_mul   = 1'b0;
    is_div   = 1'b0;
    case (bus.opcode)
      6'b000100: sel = bus.sum;
      6'b000101: sel = bus.diff;
      6'b000110: sel = bus.negate;
      6'b000111: is_mul = 1'b1;
      6'b001000: begin
        sel    = bus.divi;
        is_div = 1'b1;
      end
      6'b001001: sel = bus.or_gat;
      6'b001010: sel = bus.xor_gat;
      6'b001011: sel = bus.nand_gat;
      6'b001100: sel = bus.nor_gat;
      6'b001101: sel = bus.xnor_gat;
      6'b001110: sel = bus.not_gat;
      default:   is_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    flag_zero_d   = flag_zero_q;
    flag_neg_d    = flag_neg_q;
    err_illegal_d = 1'b0;
    err_div0_d    = 1'b0;
    retired_d     = retired_q;
    hi_data_d     = hi_data_q;
    hi_addr_d     = hi_addr_q;

    case (state_q)
      BUSY_HI: begin
        // Second MUL write: high word latched at accept; flags already set.
        wr_en_d   = 1'b1;
        wr_addr_d = hi_addr_q;
        wr_data_d = hi_data_q;
        state_d   = IDLE;
      end
      default: begin
        if (accept) begin
          if (!is_legal) begin
            err_illegal_d = 1'b1;
          end else if (is_mul) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = bus.rdst1;
            wr_data_d   = bus.multiplied[WIDTH-1:0];
            flag_zero_d = (bus.multiplied == '0);
            flag_neg_d  = bus.multiplied[2*WIDTH-1];
            hi_data_d   = bus.multiplied[2*WIDTH-1:WIDTH];
            hi_addr_d   = bus.rdst2;
            retired_d   = retired_q + CNT_W'(1);
            state_d     = BUSY_HI;
          end else if (is_div && (bus.op_a == '0)) begin
            err_div0_d = 1'b1;
            retired_d  = retired_q + CNT_W'(1);
          end else begin
            wr_en_d     = 1'b1;
            wr_addr_d   = bus.rdst1;
            wr_data_d   = sel;
            flag_zero_d = (sel == '0);
            flag_neg_d  = sel[WIDTH-1];
            retired_d   = retired_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      flag_zero_q   <= 1'b0;
      flag_neg_q    <= 1'b0;
      err_illegal_q <= 1'b0;
      err_div0_q    <= 1'b0;
      retired_q     <= '0;
      hi_data_q     <= '0;
      hi_addr_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      flag_zero_q   <= flag_zero_d;
      flag_neg_q    <= flag_neg_d;
      err_illegal_q <= err_illegal_d;
      err_div0_q    <= err_div0_d;
      retired_q     <= retired_d;
      hi_data_q     <= hi_data_d;
      hi_addr_q     <= hi_addr_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign flag_zero   = flag_zero_q;
  assign flag_neg    = flag_neg_q;
  assign err_illegal = err_illegal_q;
  assign err_div0    = err_div0_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed-vector bench for alu_writeback.
//   u_dut  : default parameters, functional vectors.
//   u_dut4 : CNT_W=4, retired-counter wrap.
module tb_alu_writeback;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_writeback_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  alu_writeback_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus4 ();

  logic              wr_en, flag_zero, flag_neg, err_illegal, err_div0;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [15:0]       retired;

  logic              wr_en4, flag_zero4, flag_neg4, err_illegal4, err_div04;
  logic [ADDR_W-1:0] wr_addr4;
  logic [WIDTH-1:0]  wr_data4;
  logic [3:0]        retired4;

  alu_writeback #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_zero(flag_zero), .flag_neg(flag_neg),
    .err_illegal(err_illegal), .err_div0(err_div0), .retired(retired)
  );

  alu_writeback #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .flag_zero(flag_zero4), .flag_neg(flag_neg4),
    .err_illegal(err_illegal4), .err_div0(err_div04), .retired(retired4)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.in_valid = 1'b0; bus.opcode = '0; bus.rdst1 = '0; bus.rdst2 = '0;
    bus.op_a = '0; bus.sum = '0; bus.diff = '0; bus.negate = '0; bus.divi = '0;
    bus.or_gat = '0; bus.xor_gat = '0; bus.nand_gat = '0; bus.nor_gat = '0;
    bus.xnor_gat = '0; bus.not_gat = '0; bus.multiplied = '0;
    bus4.in_valid = 1'b0; bus4.opcode = '0; bus4.rdst1 = '0; bus4.rdst2 = '0;
    bus4.op_a = '0; bus4.sum = '0; bus4.diff = '0; bus4.negate = '0; bus4.divi = '0;
    bus4.or_gat = '0; bus4.xor_gat = '0; bus4.nand_gat = '0; bus4.nor_gat = '0;
    bus4.xnor_gat = '0; bus4.not_gat = '0; bus4.multiplied = '0;
  endtask

  initial begin
    clear_bus();
    #12;
    // Reset state
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();

    // ADD
    bus.in_valid = 1'b1; bus.opcode = 6'b000100; bus.sum = 16'h1234; bus.rdst1 = 5'd3;
    step();
    bus.in_valid = 1'b0;
    chk("add_wr_en", 32'(wr_en), 32'd1);
    chk("add_wr_addr", 32'(wr_addr), 32'd3);
    chk("add_wr_data", 32'(wr_data), 32'h1234);
    chk("add_fz", 32'(flag_zero), 32'd0);
    chk("add_fn", 32'(flag_neg), 32'd0);
    chk("add_retired", 32'(retired), 32'd1);

    // MUL with in_valid held; next ADD waits for BUSY_HI to end
    bus.in_valid = 1'b1; bus.opcode = 6'b000111; bus.multiplied = 32'h8000_0001;
    bus.rdst1 = 5'd4; bus.rdst2 = 5'd5;
    step();
    chk("mul_lo_wr_en", 32'(wr_en), 32'd1);
    chk("mul_lo_addr", 32'(wr_addr), 32'd4);
    chk("mul_lo_data", 32'(wr_data), 32'h0001);
    chk("mul_fn", 32'(flag_neg), 32'd1);
    chk("mul_fz", 32'(flag_zero), 32'd0);
    chk("mul_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mul_retired", 32'(retired), 32'd2);
    bus.opcode = 6'b000100; bus.sum = 16'h5555; bus.rdst1 = 5'd9;
    bus.multiplied = 32'hDEAD_BEEF;
    step();
    chk("mul_hi_wr_en", 32'(wr_en), 32'd1);
    chk("mul_hi_addr", 32'(wr_addr), 32'd5);
    chk("mul_hi_data", 32'(wr_data), 32'h8000);
    chk("mul_hi_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mul_hi_retired", 32'(retired), 32'd2);
    step();
    bus.in_valid = 1'b0;
    chk("post_mul_addr", 32'(wr_addr), 32'd9);
    chk("post_mul_data", 32'(wr_data), 32'h5555);
    chk("post_mul_retired", 32'(retired), 32'd3);
    step();
    chk("idle_wr_en", 32'(wr_en), 32'd0);
    chk("idle_addr_hold", 32'(wr_addr), 32'd9);

    // Back-to-back SUB (zero) then NOT (0xFFFF)
    bus.in_valid = 1'b1; bus.opcode = 6'b000101; bus.diff = 16'h0000; bus.rdst1 = 5'd1;
    step();
    chk("sub_wr_en", 32'(wr_en), 32'd1);
    chk("sub_data", 32'(wr_data), 32'h0000);
    chk("sub_fz", 32'(flag_zero), 32'd1);
    chk("sub_fn", 32'(flag_neg), 32'd0);
    bus.opcode = 6'b001110; bus.not_gat = 16'hFFFF; bus.rdst1 = 5'd2;
    step();
    bus.in_valid = 1'b0;
    chk("not_wr_en", 32'(wr_en), 32'd1);
    chk("not_addr", 32'(wr_addr), 32'd2);
    chk("not_data", 32'(wr_data), 32'hFFFF);
    chk("not_fz", 32'(flag_zero), 32'd0);
    chk("not_fn", 32'(flag_neg), 32'd1);
    chk("not_retired", 32'(retired), 32'd5);

    // DIV by zero
    bus.in_valid = 1'b1; bus.opcode = 6'b001000; bus.op_a = 16'h0000; bus.divi = 16'h0007;
    bus.rdst1 = 5'd8;
    step();
    bus.in_valid = 1'b0;
    chk("div0_wr_en", 32'(wr_en), 32'd0);
    chk("div0_pulse", 32'(err_div0), 32'd1);
    chk("div0_illegal", 32'(err_illegal), 32'd0);
    chk("div0_fz", 32'(flag_zero), 32'd0);
    chk("div0_fn", 32'(flag_neg), 32'd1);
    chk("div0_retired", 32'(retired), 32'd6);
    step();
    chk("div0_pulse_end", 32'(err_div0), 32'd0);

    // Illegal opcode 000011
    bus.in_valid = 1'b1; bus.opcode = 6'b000011;
    step();
    bus.in_valid = 1'b0;
    chk("ill_pulse", 32'(err_illegal), 32'd1);
    chk("ill_wr_en", 32'(wr_en), 32'd0);
    chk("ill_retired", 32'(retired), 32'd6);
    chk("ill_fn", 32'(flag_neg), 32'd1);
    step();
    chk("ill_pulse_end", 32'(err_illegal), 32'd0);

    // Normal DIV (op_a nonzero)
    bus.in_valid = 1'b1; bus.opcode = 6'b001000; bus.op_a = 16'h0003; bus.divi = 16'h0002;
    bus.rdst1 = 5'd7;
    step();
    bus.in_valid = 1'b0;
    chk("div_wr_en", 32'(wr_en), 32'd1);
    chk("div_data", 32'(wr_data), 32'h0002);
    chk("div_err", 32'(err_div0), 32'd0);
    chk("div_retired", 32'(retired), 32'd7);

    // MUL with rdst1 == rdst2
    bus.in_valid = 1'b1; bus.opcode = 6'b000111; bus.multiplied = 32'hABCD_0001;
    bus.rdst1 = 5'd6; bus.rdst2 = 5'd6;
    step();
    bus.in_valid = 1'b0;
    chk("mulsame_lo_addr", 32'(wr_addr), 32'd6);
    chk("mulsame_lo_data", 32'(wr_data), 32'h0001);
    step();
    chk("mulsame_hi_wr_en", 32'(wr_en), 32'd1);
    chk("mulsame_hi_addr", 32'(wr_addr), 32'd6);
    chk("mulsame_hi_data", 32'(wr_data), 32'hABCD);

    // Async reset during BUSY_HI
    step();
    bus.in_valid = 1'b1; bus.opcode = 6'b000111; bus.multiplied = 32'h1234_0000;
    bus.rdst1 = 5'd10; bus.rdst2 = 5'd11;
    step();
    bus.in_valid = 1'b0;
    chk("mulrst_lo_data", 32'(wr_data), 32'h0000);
    chk("mulrst_fz", 32'(flag_zero), 32'd0);
    chk("mulrst_busy", 32'(bus.in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_addr", 32'(wr_addr), 32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_no_hi_wr", 32'(wr_en), 32'd0);
    chk("arst_no_hi_addr", 32'(wr_addr), 32'd0);

    // CNT_W=4 wrap: 17 back-to-back ADDs
    bus4.in_valid = 1'b1; bus4.opcode = 6'b000100; bus4.sum = 16'h0011; bus4.rdst1 = 5'd2;
    for (int i = 0; i < 14; i++) step();
    step();
    chk("wrap_15", 32'(retired4), 32'd15);
    step();
    chk("wrap_0", 32'(retired4), 32'd0);
    step();
    bus4.in_valid = 1'b0;
    chk("wrap_1", 32'(retired4), 32'd1);
    chk("wrap_wr_en", 32'(wr_en4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Writeback stage directly downstream of the ALU result mux in the 16-bit Harvard datapath. It accepts one decoded ALU instruction per handshake, selects the matching result word by opcode, and drives the register-file write port. MUL writes its 32-bit product over two cycles to Rdst1 (low word) and Rdst2 (high word). It also keeps the zero/negative flags, error pulses and a retired-instruction counter.

Parameters:
WIDTH, 16, datapath word width
ADDR_W, 5, register address width (matches the 5-bit Rdst fields in code[25:21] and code[20:16])
CNT_W, 16, width of the retired counter

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction and ALU results are valid
in_ready  output  1  stage can accept; combinational, equals (state != BUSY_HI)
opcode  input  6  code[31:26]
rdst1  input  ADDR_W  low/primary destination register
rdst2  input  ADDR_W  high-word destination register (used only by MUL)
op_a  input  WIDTH  divisor operand, for divide-by-zero detection
sum, diff, negate, divi, or_gat, xor_gat, nand_gat, nor_gat, xnor_gat, not_gat  input  WIDTH each  ALU results
multiplied  input  2*WIDTH  MUL product
wr_en  output  1  register-file write strobe, registered
wr_addr  output  ADDR_W  write address, registered
wr_data  output  WIDTH  write data, registered
flag_zero  output  1  zero flag of the last retired result
flag_neg  output  1  sign flag of the last retired result
err_illegal  output  1  one-cycle pulse for an unsupported opcode
err_div0  output  1  one-cycle pulse for DIV with op_a==0
retired  output  CNT_W  count of retired instructions; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, active-high) forces all outputs to 0, state IDLE and retired 0.
- A pending MUL high word is discarded if reset arrives mid-operation.
- Accept occurs when in_valid && in_ready at a rising edge. Inputs are sampled only on accept; there is no input hold requirement afterwards.
- States: IDLE and BUSY_HI.
- Opcode to result mapping: 000100 sum, 000101 diff, 000110 negate, 001000 divi, 001001 or_gat, 001010 xor_gat, 001011 nand_gat, 001100 nor_gat, 001101 xnor_gat, 001110 not_gat, 000111 MUL.
- Single-word op accepted at edge N:
  - wr_en=1, wr_addr=rdst1, wr_data=selected result during cycle N+1.
  - flag_zero and flag_neg are updated from that word.
  - retired increments at the same edge.
  - State stays IDLE, so back-to-back accepts give one write per cycle.
- MUL accepted at edge N:
  - Cycle N+1: write multiplied[WIDTH-1:0] to rdst1; flags taken from the full 2*WIDTH product (zero if all bits 0, neg = MSB); retired increments; state goes to BUSY_HI.
  - in_ready is low during BUSY_HI.
  - Edge N+1: the stored high word is registered. Cycle N+2: write multiplied[2*WIDTH-1:WIDTH] to rdst2; state returns to IDLE.
  - The high word is latched at accept, not re-read.
- MUL with rdst1==rdst2: both writes occur in order, so the high word remains in the register.
- DIV with op_a==0: no write, flags unchanged, err_div0 pulses in cycle N+1, retired still increments.
- Any other opcode (MOV, LOAD, STORE, shifts, undefined): no write, flags unchanged, err_illegal pulses in cycle N+1, retired does not increment.
- wr_en, err_illegal and err_div0 return to 0 in every cycle without a qualifying event. wr_addr and wr_data hold their last values when wr_en=0.
- retired wraps from 2^CNT_W-1 to 0 with no other side effect.

Test Plan:
- Reset then ADD (opcode 000100, sum=0x1234, rdst1=3) -> next cycle wr_en=1, wr_addr=3, wr_data=0x1234, flag_zero=0, flag_neg=0, retired=1.
- MUL with multiplied=0x8000_0001, rdst1=4, rdst2=5, in_valid held high -> cycle 1 writes reg4=0x0001, flag_neg=1, in_ready=0; cycle 2 writes reg5=0x8000; the next instruction is accepted only after BUSY_HI.
- Back-to-back SUB (diff=0) then NOT (not_gat=0xFFFF) -> consecutive wr_en cycles; flag_zero=1 then flag_neg=1, flag_zero=0.
- DIV with op_a=0 -> no wr_en, err_div0 pulses 1 cycle, flags unchanged, retired increments; opcode 000011 -> err_illegal pulse, retired unchanged.
- rst asserted asynchronously during BUSY_HI -> outputs 0 immediately, no high-word write after release, in_ready=1.
- CNT_W=4, 17 ADDs -> retired reads 15, then 0, then 1.
